// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single read/write port of the data memory between the core
// (requester 0) and a debug/program loader (requester 1). Arbitration is
// round-robin with an optional bounded lock, so one requester can hold the
// port for a burst. Each read is tagged so the data is returned only to the
// requester that issued it.
module mem_port_arbiter #(
   parameter int N        = 32,
   parameter int MAX_HOLD = 8
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         m0_req,
   input  logic         m1_req,
   input  logic         m0_we,
   input  logic         m1_we,
   input  logic         m0_lock,
   input  logic         m1_lock,
   input  logic [N-1:0] m0_addr,
   input  logic [N-1:0] m1_addr,
   input  logic [N-1:0] m0_wdata,
   input  logic [N-1:0] m1_wdata,
   output logic         m0_gnt,
   output logic         m1_gnt,
   output logic         m0_rvalid,
   output logic         m1_rvalid,
   output logic [N-1:0] m0_rdata,
   output logic [N-1:0] m1_rdata,
   output logic         mem_wr_ena,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wr_data,
   input  logic [N-1:0] mem_rd_data,
   output logic [1:0]   owner
);

   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   logic [1:0]    state, state_nxt;
   logic          last, last_nxt;      // id of the most recent grant
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [1:0]    rd_pend, rd_pend_nxt;

   logic          idle_g0, idle_g1;
   logic          g0, g1;

   // Round-robin choice used whenever no lock is in force.
   always_comb begin
      // On a tie the requester that was not granted last wins.
      idle_g0 = m0_req & (~m1_req | last);
      idle_g1 = m1_req & (~m0_req | ~last);
   end

   // Grant selection: honour the lock unless its holder dropped req or the
   // hold budget is spent while the other side is waiting.
   always_comb begin
      // NOTE: every combinational output gets a default first so that no path
      // through the case leaves it unassigned, which would infer a latch.
      g0 = idle_g0;
      g1 = idle_g1;
      case (state)
         LOCK0: begin
            if (m0_req) begin
               g1 = (hold_cnt == HOLD_MAX) & m1_req;
               g0 = ~g1;
            end
         end
         LOCK1: begin
            if (m1_req) begin
               g0 = (hold_cnt == HOLD_MAX) & m0_req;
               g1 = ~g0;
            end
         end
         default: ;
      endcase
   end

   // NOTE: grants are gated with the asynchronous reset so that the memory
   // port is quiet while rstb is low, even with requests asserted.
   assign m0_gnt = g0 & rstb;
   assign m1_gnt = g1 & rstb;
   assign owner  = {m1_gnt, m0_gnt};

   // Next-state, round-robin pointer, hold counter and read tag.
   always_comb begin
      state_nxt   = IDLE;
      last_nxt    = last;
      hold_nxt    = '0;
      rd_pend_nxt = 2'b00;
      if (m0_gnt) begin
         last_nxt    = 1'b0;
         rd_pend_nxt = {1'b0, ~m0_we};
         if (m0_lock) state_nxt = LOCK0;
         if (state == LOCK0)
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
         else if (m0_lock)
            hold_nxt = HW'(1);
      end else if (m1_gnt) begin
         last_nxt    = 1'b1;
         rd_pend_nxt = {~m1_we, 1'b0};
         if (m1_lock) state_nxt = LOCK1;
         if (state == LOCK1)
            hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
         else if (m1_lock)
            hold_nxt = HW'(1);
      end
   end

   // State registers; reset leaves m0 as winner of the first tie.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
         rd_pend  <= 2'b00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
         rd_pend  <= rd_pend_nxt;
      end
   end

   // Memory port is driven from the granted requester, all-zero otherwise.
   always_comb begin
      mem_wr_ena  = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (m0_gnt) begin
         mem_wr_ena  = m0_we;
         mem_addr    = m0_addr;
         mem_wr_data = m0_wdata;
      end else if (m1_gnt) begin
         mem_wr_ena  = m1_we;
         mem_addr    = m1_addr;
         mem_wr_data = m1_wdata;
      end
   end

   // Read data is steered to the requester whose read was tagged last cycle.
   assign m0_rvalid = rd_pend[0];
   assign m1_rvalid = rd_pend[1];
   assign m0_rdata  = rd_pend[0] ? mem_rd_data : '0;
   assign m1_rdata  = rd_pend[1] ? mem_rd_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: drives both requesters, models the synchronous
// memory behind the port, and scoreboards every read return.
module tb_mem_port_arbiter;

   localparam int N        = 32;
   localparam int MAX_HOLD = 4;
   localparam logic [N-1:0] D4 = 32'hA5A5_0004;
   localparam logic [N-1:0] D8 = 32'h5A5A_0008;

   logic         clk = 1'b0;
   logic         rstb;
   logic         m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
   logic [N-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
   logic         m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [N-1:0] m0_rdata, m1_rdata;
   logic         mem_wr_ena;
   logic [N-1:0] mem_addr, mem_wr_data, mem_rd_data;
   logic [1:0]   owner;

   mem_port_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk), .rstb(rstb),
      .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
      .m0_lock(m0_lock), .m1_lock(m1_lock),
      .m0_addr(m0_addr), .m1_addr(m1_addr),
      .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
      .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
      .owner(owner)
   );

   always #5 clk = ~clk;

   // Memory model: synchronous read (read-first), write on the edge; a
   // separate preload port fills it before the tests.
   logic [N-1:0] dmem [0:255];
   logic         pre_we = 1'b0;
   logic [7:0]   pre_addr = 8'd0;
   logic [N-1:0] pre_data = '0;
   always @(posedge clk) begin
      if (pre_we)          dmem[pre_addr] <= pre_data;
      else if (mem_wr_ena) dmem[mem_addr[7:0]] <= mem_wr_data;
      mem_rd_data <= dmem[mem_addr[7:0]];
   end

   typedef struct packed {
      logic [1:0]   who;   // one-hot requester expected to see rvalid
      logic [N-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Scoreboard: after each edge, the oldest expected read must be on the
   // bus; with nothing expected, both rvalid and both rdata must be quiet.
   initial begin
      exp_t         e;
      logic [N-1:0] got;
      forever begin
         @(posedge clk);
         #3;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = e.who[0] ? m0_rdata : m1_rdata;
            vectors++;
            if ({m1_rvalid, m0_rvalid} !== e.who) begin
               miscompares++;
               $display("FAIL rvalid @%0t: got %b expected %b", $time, {m1_rvalid, m0_rvalid}, e.who);
            end
            vectors++;
            if (got !== e.data) begin
               miscompares++;
               $display("FAIL rdata @%0t: got %h expected %h", $time, got, e.data);
            end
         end else begin
            vectors++;
            if ({m1_rvalid, m0_rvalid, m0_rdata, m1_rdata} !== '0) begin
               miscompares++;
               $display("FAIL quiet_rvalid @%0t: rvalid %b rdata0 %h rdata1 %h expected all zero",
                        $time, {m1_rvalid, m0_rvalid}, m0_rdata, m1_rdata);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input logic req, input logic we, input logic lock,
                        input logic [N-1:0] addr, input logic [N-1:0] wdata);
      if (id == 0) begin
         m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   task automatic idle_inputs();
      drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic apply_reset();
      idle_inputs();
      step();
      step();
      rstb = 1'b0;
      step();
      rstb = 1'b1;
   endtask

   // Outputs are zero while reset is held, even with both requesting writes.
   task automatic test_reset();
      rstb = 1'b0;
      drive(0, 1'b1, 1'b1, 1'b1, 32'h55, 32'h1111_2222);
      drive(1, 1'b1, 1'b1, 1'b1, 32'h66, 32'h3333_4444);
      @(negedge clk);
      vectors++;
      if ({m1_gnt, m0_gnt, owner, mem_wr_ena, mem_addr, mem_wr_data,
           m1_rvalid, m0_rvalid, m0_rdata, m1_rdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: gnt %b owner %b we %b addr %h wdata %h expected all zero",
                  {m1_gnt, m0_gnt}, owner, mem_wr_ena, mem_addr, mem_wr_data);
      end
      step();
      pre_we = 1'b1; pre_addr = 8'd4; pre_data = D4;
      step();
      pre_addr = 8'd8; pre_data = D8;
      step();
      pre_we = 1'b0;
      idle_inputs();
      rstb = 1'b1;
   endtask

   // Both requesters read continuously without lock: strict alternation.
   task automatic test_alternate();
      logic [1:0]   exp_own;
      logic [N-1:0] exp_addr;
      drive(0, 1'b1, 1'b0, 1'b0, 32'h4, '0);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h8, '0);
      for (int i = 0; i < 6; i++) begin
         exp_own  = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (i % 2 == 0) ? 32'h4 : 32'h8;
         @(negedge clk);
         vectors++;
         if ({owner, m1_gnt, m0_gnt, mem_wr_ena, mem_addr} !== {exp_own, exp_own, 1'b0, exp_addr}) begin
            miscompares++;
            $display("FAIL alternate[%0d]: owner %b gnt %b we %b addr %h expected owner %b addr %h",
                     i, owner, {m1_gnt, m0_gnt}, mem_wr_ena, mem_addr, exp_own, exp_addr);
         end
         exp_q.push_back('{who: exp_own, data: (i % 2 == 0) ? D4 : D8});
         step();
      end
      idle_inputs();
      step();
   endtask

   // m1 writes, m0 reads the same word back on the following cycle.
   task automatic test_single_write();
      drive(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      vectors++;
      if ({owner, mem_wr_ena, mem_addr, mem_wr_data} !== {2'b10, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
         miscompares++;
         $display("FAIL write_cycle: owner %b we %b addr %h wdata %h expected 10 1 00000010 deadbeef",
                  owner, mem_wr_ena, mem_addr, mem_wr_data);
      end
      step();
      drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(0, 1'b1, 1'b0, 1'b0, 32'h10, '0);
      @(negedge clk);
      vectors++;
      if ({owner, mem_wr_ena, mem_addr} !== {2'b01, 1'b0, 32'h10}) begin
         miscompares++;
         $display("FAIL readback_cycle: owner %b we %b addr %h expected 01 0 00000010",
                  owner, mem_wr_ena, mem_addr);
      end
      exp_q.push_back('{who: 2'b01, data: 32'hDEAD_BEEF});
      step();
      idle_inputs();
      step();
   endtask

   // m0 holds lock while m1 keeps asking: MAX_HOLD grants to m0, then m1.
   task automatic test_lock_burst();
      logic [1:0] seq [10];
      seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      apply_reset();
      drive(0, 1'b1, 1'b0, 1'b1, 32'h4, '0);
      drive(1, 1'b1, 1'b0, 1'b0, 32'h8, '0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if (owner !== seq[i]) begin
            miscompares++;
            $display("FAIL lock_burst[%0d]: owner %b expected %b", i, owner, seq[i]);
         end
         exp_q.push_back('{who: seq[i], data: (seq[i] == 2'b01) ? D4 : D8});
         step();
      end
      idle_inputs();
      step();
   endtask

   // Lock holder drops req: the other requester is granted in that cycle,
   // and the following tie is resolved by round-robin from IDLE.
   task automatic test_lock_release();
      logic [1:0] seq [3];
      seq = '{2'b01, 2'b10, 2'b01};
      drive(0, 1'b1, 1'b0, 1'b1, 32'h4, '0);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) begin
            drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
            drive(1, 1'b1, 1'b0, 1'b0, 32'h8, '0);
         end else if (i == 2) begin
            drive(0, 1'b1, 1'b0, 1'b0, 32'h4, '0);
         end
         @(negedge clk);
         vectors++;
         if ({owner, m1_gnt, m0_gnt} !== {seq[i], seq[i]}) begin
            miscompares++;
            $display("FAIL lock_release[%0d]: owner %b gnt %b expected %b", i, owner, {m1_gnt, m0_gnt}, seq[i]);
         end
         exp_q.push_back('{who: seq[i], data: (seq[i] == 2'b01) ? D4 : D8});
         step();
      end
      idle_inputs();
      step();
   endtask

   // Reset between a read grant and its return drops the read.
   task automatic test_reset_mid_read();
      apply_reset();
      drive(0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h7777_7777);
      @(negedge clk);
      vectors++;
      if (owner !== 2'b01) begin
         miscompares++;
         $display("FAIL midread_grant: owner %b expected 01", owner);
      end
      step();
      rstb = 1'b0;
      drive(1, 1'b1, 1'b0, 1'b0, 32'h8, 32'h8888_8888);
      #1;
      vectors++;
      if ({m1_gnt, m0_gnt, owner, mem_wr_ena, mem_addr, mem_wr_data,
           m1_rvalid, m0_rvalid, m0_rdata, m1_rdata} !== '0) begin
         miscompares++;
         $display("FAIL midread_reset_outputs: gnt %b owner %b addr %h wdata %h rvalid %b expected all zero",
                  {m1_gnt, m0_gnt}, owner, mem_addr, mem_wr_data, {m1_rvalid, m0_rvalid});
      end
      step();
      rstb = 1'b1;
      @(negedge clk);
      vectors++;
      if (owner !== 2'b01) begin
         miscompares++;
         $display("FAIL post_reset_tie: owner %b expected 01", owner);
      end
      exp_q.push_back('{who: 2'b01, data: D4});
      step();
      idle_inputs();
      step();
   endtask

   // No requests: the memory port stays at zero for ten cycles.
   task automatic test_idle();
      idle_inputs();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         vectors++;
         if ({owner, mem_wr_ena, mem_addr, mem_wr_data} !== '0) begin
            miscompares++;
            $display("FAIL idle[%0d]: owner %b we %b addr %h wdata %h expected all zero",
                     i, owner, mem_wr_ena, mem_addr, mem_wr_data);
         end
      end
      step();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alternate();
      test_single_write();
      test_lock_burst();
      test_lock_release();
      test_reset_mid_read();
      test_idle();
      step();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d reads still outstanding, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
